// File: rtl/eim_mem_slave_pkg.sv
// Shared definitions for the EIM async-mode memory slave:
// FSM state encoding, default synchroniser depth and out-of-range read value.
package eim_mem_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_RFETCH = 3'd2,
        ST_RDRIVE = 3'd3,
        ST_WBEAT  = 3'd4
    } eim_state_e;

    localparam int EIM_SYNC_DEFAULT = 2;
    localparam int EIM_OOR_DATA     = 0;

endpackage

// File: rtl/eim_mem_slave_if.sv
// EIM multiplexed address/data bus as seen by this slave.
// The master modport is the pad/host side, the slave modport is this block.
interface eim_mem_slave_if #(
    parameter int DATA_W = 16
);
    logic              eim_cs0_n;
    logic              eim_lba_n;
    logic              eim_wr_n;
    logic              eim_oe_n;
    logic [DATA_W-1:0] eim_da_in;
    logic [DATA_W-1:0] eim_da_out;
    logic              eim_da_oe;
    logic              eim_wait_n;

    modport master (
        output eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n, eim_da_in,
        input  eim_da_out, eim_da_oe, eim_wait_n
    );

    modport slave (
        input  eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n, eim_da_in,
        output eim_da_out, eim_da_oe, eim_wait_n
    );

endinterface

// File: rtl/eim_mem_slave_sync_edge.sv
// Single-bit synchroniser with edge detection. The level is the last
// synchroniser stage; rise/fall compare it with a one-flop delayed copy.
module eim_sync_edge
    import eim_mem_slave_pkg::*;
#(
    parameter int   SYNC_STAGES = EIM_SYNC_DEFAULT,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    // Shift the async input through the synchroniser chain and keep one delayed copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_dly  <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_dly;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_dly;

endmodule

// File: rtl/eim_mem_slave.sv
// EIM async-mode slave: synchronises the EIM strobes, latches the address
// on LBA, prefetches read data every beat, and serves auto-incrementing
// read/write bursts into a flop register file. Word 0 is exported as reg0.
module eim_mem_slave
    import eim_mem_slave_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int MEM_DEPTH   = 16,
    parameter int SYNC_STAGES = EIM_SYNC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    eim_mem_slave_if.slave        bus,
    output logic [DATA_W-1:0]     reg0,
    output logic                  err_oor
);
    // Synchronised strobe levels and edges
    logic w_cs_lvl,  w_cs_rise,  w_cs_fall;
    logic w_lba_lvl, w_lba_rise, w_lba_fall;
    logic w_wr_lvl,  w_wr_rise,  w_wr_fall;
    logic w_oe_lvl,  w_oe_rise,  w_oe_fall;
    logic w_unused_edges;

    eim_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .i_async(bus.eim_cs0_n),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    eim_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_lba (
        .clk(clk), .rst(rst), .i_async(bus.eim_lba_n),
        .o_level(w_lba_lvl), .o_rise(w_lba_rise), .o_fall(w_lba_fall)
    );
    eim_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wr (
        .clk(clk), .rst(rst), .i_async(bus.eim_wr_n),
        .o_level(w_wr_lvl), .o_rise(w_wr_rise), .o_fall(w_wr_fall)
    );
    eim_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_oe (
        .clk(clk), .rst(rst), .i_async(bus.eim_oe_n),
        .o_level(w_oe_lvl), .o_rise(w_oe_rise), .o_fall(w_oe_fall)
    );

    assign w_unused_edges = &{1'b0, w_cs_fall, w_lba_lvl, w_wr_lvl, w_oe_fall};

    // da bus synchroniser, same depth as the strobes so data and edges line up
    logic [DATA_W-1:0] r_da_sync [SYNC_STAGES];
    logic [DATA_W-1:0] w_da_s;

    // Shift the da bus through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_da_sync[i] <= '0;
        end else begin
            r_da_sync[0] <= bus.eim_da_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_da_sync[i] <= r_da_sync[i-1];
        end
    end

    assign w_da_s = r_da_sync[SYNC_STAGES-1];

    // State, address pointer, read buffer and register file
    eim_state_e        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dout;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    logic              w_latch;
    logic              w_rd_beat;
    logic              w_commit;
    logic              w_fetch;
    logic              w_da_oe;
    logic              w_wait_n;
    logic              w_oor;
    logic [DATA_W-1:0] w_rd_data;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: CS release aborts everything, a new LBA restarts the transaction.
    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_rise) begin
            w_state_nxt = ST_IDLE;
        end else if (!w_cs_lvl && w_lba_fall) begin
            w_state_nxt = ST_ADDR;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_nxt = ST_IDLE;
                ST_ADDR:   if (w_lba_rise) w_state_nxt = ST_RFETCH;
                ST_RFETCH: w_state_nxt = ST_RDRIVE;
                ST_RDRIVE: begin
                    // A finishing read beat wins over a write starting on the same clock
                    if (w_oe_rise)      w_state_nxt = ST_RFETCH;
                    else if (w_wr_fall) w_state_nxt = ST_WBEAT;
                end
                ST_WBEAT:  if (w_wr_rise) w_state_nxt = ST_RFETCH;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs and datapath strobes decoded from the current state and transition.
    always_comb begin
        w_latch   = !w_cs_rise && !w_cs_lvl && w_lba_fall;
        w_rd_beat = (r_state == ST_RDRIVE) && (w_state_nxt == ST_RFETCH);
        w_commit  = (r_state == ST_WBEAT)  && (w_state_nxt == ST_RFETCH);
        w_fetch   = (r_state == ST_RFETCH) && (w_state_nxt == ST_RDRIVE);
        w_wait_n  = (r_state != ST_RFETCH);
        w_da_oe   = (r_state == ST_RDRIVE) && !w_oe_lvl && !w_cs_lvl;
    end

    assign w_oor = ({1'b0, r_addr} >= (ADDR_W+1)'(MEM_DEPTH));

    // Read mux; out-of-range addresses return the fixed OOR value.
    always_comb begin
        w_rd_data = DATA_W'(EIM_OOR_DATA);
        for (int i = 0; i < MEM_DEPTH; i++) begin
            if (r_addr == ADDR_W'(i)) w_rd_data = r_mem[i];
        end
    end

    // Address pointer (wraps at 2^ADDR_W), read buffer and sticky out-of-range flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_dout <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_latch)                    r_addr <= w_da_s[ADDR_W-1:0];
            else if (w_rd_beat || w_commit) r_addr <= r_addr + ADDR_W'(1);

            if (w_fetch) r_dout <= w_rd_data;

            if ((w_fetch || w_commit) && w_oor)
                r_err <= 1'b1;
            else if (w_commit && (r_addr == '0) && (w_da_s == '0))
                r_err <= 1'b0;
        end
    end

    // Register file write on the write-strobe release; out-of-range writes are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                if (r_addr == ADDR_W'(i)) r_mem[i] <= w_da_s;
            end
        end
    end

    assign bus.eim_da_out = r_dout;
    assign bus.eim_da_oe  = w_da_oe;
    assign bus.eim_wait_n = w_wait_n;
    assign reg0           = r_mem[0];
    assign err_oor        = r_err;

endmodule

// File: tb/tb_eim_mem_slave.sv
// Self-checking bench for eim_mem_slave: directed vector table, hand-written
// corner sequences and randomized bursts checked against a transaction model.
module tb_eim_mem_slave;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 16;
    localparam int SS    = 2;

    logic          clk;
    logic          rst;
    logic [DW-1:0] reg0;
    logic          err_oor;

    eim_mem_slave_if #(.DATA_W(DW)) bus ();

    eim_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .bus(bus), .reg0(reg0), .err_oor(err_oor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model: word array, sticky error, burst pointer
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_err;
    int            m_ptr;

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_err = 0;
        m_ptr = 0;
    endfunction

    function automatic void m_prefetch();
        if (m_ptr >= DEPTH) m_err = 1;
    endfunction

    function automatic void m_start(input int a);
        m_ptr = a % 256;
        m_prefetch();
    endfunction

    function automatic logic [DW-1:0] m_read();
        logic [DW-1:0] v;
        v = '0;
        if (m_ptr < DEPTH) v = m_mem[m_ptr];
        m_ptr = (m_ptr + 1) % 256;
        m_prefetch();
        return v;
    endfunction

    function automatic void m_write(input logic [DW-1:0] d);
        if (m_ptr < DEPTH) begin
            m_mem[m_ptr] = d;
            if (m_ptr == 0 && d == '0) m_err = 0;
        end else begin
            m_err = 1;
        end
        m_ptr = (m_ptr + 1) % 256;
        m_prefetch();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start(input logic [DW-1:0] da);
        bus.eim_cs0_n = 1'b0;
        bus.eim_da_in = da;
        bus.eim_lba_n = 1'b0;
        cyc(6);
        bus.eim_lba_n = 1'b1;
        cyc(8);
        m_start(int'(da[AW-1:0]));
    endtask

    task automatic bus_write(input logic [DW-1:0] d);
        bus.eim_wr_n  = 1'b0;
        bus.eim_da_in = d;
        cyc(6);
        bus.eim_wr_n  = 1'b1;
        cyc(8);
        m_write(d);
    endtask

    task automatic bus_read(output logic [DW-1:0] got, output logic oe_seen,
                            output logic wait_pulse, output logic [DW-1:0] exp);
        bus.eim_oe_n = 1'b0;
        cyc(6);
        got     = bus.eim_da_out;
        oe_seen = bus.eim_da_oe;
        bus.eim_oe_n = 1'b1;
        wait_pulse = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cyc(1);
            if (!bus.eim_wait_n) wait_pulse = 1'b1;
        end
        exp = m_read();
    endtask

    task automatic bus_end();
        bus.eim_cs0_n = 1'b1;
        cyc(6);
    endtask

    typedef struct {
        bit            wr;
        logic [DW-1:0] da_addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        logic [DW-1:0] exp_reg0;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] got, exp;
        logic          oe_seen, wpulse;
        int            lo_at, hi_at;

        tbl[0]  = '{1'b1, 16'h0003, 16'hBEEF, 16'h0000, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 16'h0003, 16'h0000, 16'hBEEF, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 16'h0000, 16'h1234, 16'h0000, 1'b0, 16'h1234};
        tbl[3]  = '{1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b0, 16'h1234};
        tbl[4]  = '{1'b1, 16'h000F, 16'hA5A5, 16'h0000, 1'b1, 16'h1234};
        tbl[5]  = '{1'b0, 16'h000F, 16'h0000, 16'hA5A5, 1'b1, 16'h1234};
        tbl[6]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        tbl[7]  = '{1'b0, 16'h0014, 16'h0000, 16'h0000, 1'b1, 16'h0000};
        tbl[8]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        tbl[9]  = '{1'b1, 16'hA1F3, 16'h7777, 16'h0000, 1'b1, 16'h0000};
        tbl[10] = '{1'b0, 16'h5503, 16'h0000, 16'hBEEF, 1'b1, 16'h0000};
        tbl[11] = '{1'b1, 16'h00FF, 16'h0000, 16'h0000, 1'b1, 16'h0000};

        rst = 1'b1;
        bus.eim_cs0_n = 1'b1;
        bus.eim_lba_n = 1'b1;
        bus.eim_wr_n  = 1'b1;
        bus.eim_oe_n  = 1'b1;
        bus.eim_da_in = '0;
        m_reset();
        cyc(3);
        rst = 1'b0;
        cyc(2);

        chk("reset_da_oe",  32'(bus.eim_da_oe),  32'd0);
        chk("reset_wait_n", 32'(bus.eim_wait_n), 32'd1);
        chk("reset_da_out", 32'(bus.eim_da_out), 32'd0);
        chk("reset_reg0",   32'(reg0),           32'd0);
        chk("reset_err",    32'(err_oor),        32'd0);

        // Directed vector table, one single-beat transaction per entry
        for (int i = 0; i < 12; i++) begin
            bus_start(tbl[i].da_addr);
            if (tbl[i].wr) begin
                bus_write(tbl[i].data);
            end else begin
                bus_read(got, oe_seen, wpulse, exp);
                chk($sformatf("tbl%0d_rdata", i), 32'(got), 32'(tbl[i].exp_rd));
                chk($sformatf("tbl%0d_da_oe", i), 32'(oe_seen), 32'd1);
            end
            bus_end();
            chk($sformatf("tbl%0d_err", i),  32'(err_oor), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_reg0", i), 32'(reg0),    32'(tbl[i].exp_reg0));
            chk($sformatf("tbl%0d_idle_oe", i), 32'(bus.eim_da_oe), 32'd0);
        end

        // Single read of addr 3 with wait_n timing after LBA release
        bus.eim_cs0_n = 1'b0;
        bus.eim_da_in = 16'h0003;
        bus.eim_lba_n = 1'b0;
        cyc(6);
        chk("rd_wait_before", 32'(bus.eim_wait_n), 32'd1);
        bus.eim_lba_n = 1'b1;
        lo_at = -1;
        hi_at = -1;
        for (int c = 1; c <= 8; c++) begin
            cyc(1);
            if (!bus.eim_wait_n && lo_at < 0) lo_at = c;
            if (bus.eim_wait_n && lo_at >= 0 && hi_at < 0) hi_at = c;
        end
        m_start(3);
        chk("rd_wait_low_seen", 32'(lo_at > 0), 32'd1);
        chk("rd_wait_high_in_time", 32'(hi_at > 0 && hi_at <= SS + 3), 32'd1);
        bus.eim_oe_n = 1'b0;
        cyc(6);
        chk("rd_da_oe_on",  32'(bus.eim_da_oe),  32'd1);
        chk("rd_da_out",    32'(bus.eim_da_out), 32'hBEEF);
        bus.eim_oe_n = 1'b1;
        cyc(8);
        exp = m_read();
        chk("rd_da_oe_off", 32'(bus.eim_da_oe),  32'd0);
        bus_end();

        // Burst write 0..3 then burst read back in order
        bus_start(16'h0000);
        bus_write(16'h0011);
        bus_write(16'h0022);
        bus_write(16'h0033);
        bus_write(16'h0044);
        bus_end();
        chk("bw_reg0", 32'(reg0), 32'h0011);
        bus_start(16'h0000);
        for (int b = 0; b < 4; b++) begin
            bus_read(got, oe_seen, wpulse, exp);
            chk($sformatf("br_data%0d", b), 32'(got), 32'(16'h0011 * (b + 1)));
            chk($sformatf("br_wait%0d", b), 32'(wpulse), 32'd1);
        end
        bus_end();

        // Burst write running past the top of memory
        bus_start(16'h000E);
        bus_write(16'hE0E0);
        bus_write(16'hF0F0);
        bus_write(16'hDEAD);
        bus_write(16'hCAFE);
        bus_end();
        chk("oor_err_set", 32'(err_oor), 32'd1);
        bus_start(16'h000E);
        bus_read(got, oe_seen, wpulse, exp);
        chk("oor_w0E", 32'(got), 32'hE0E0);
        bus_read(got, oe_seen, wpulse, exp);
        chk("oor_w0F", 32'(got), 32'hF0F0);
        bus_end();
        bus_start(16'h0000);
        bus_read(got, oe_seen, wpulse, exp);
        chk("oor_no_alias0", 32'(got), 32'h0011);
        bus_read(got, oe_seen, wpulse, exp);
        chk("oor_no_alias1", 32'(got), 32'h0022);
        bus_end();
        bus_start(16'h0000);
        bus_write(16'h0000);
        bus_end();
        chk("oor_err_clear", 32'(err_oor), 32'd0);
        chk("oor_reg0_zero", 32'(reg0),    32'd0);

        // CS released between write strobe fall and rise
        bus_start(16'h0005);
        bus_write(16'h5555);
        bus_end();
        bus_start(16'h0005);
        bus.eim_wr_n  = 1'b0;
        bus.eim_da_in = 16'h9999;
        cyc(6);
        bus.eim_cs0_n = 1'b1;
        cyc(6);
        chk("abort_da_oe",  32'(bus.eim_da_oe),  32'd0);
        chk("abort_wait_n", 32'(bus.eim_wait_n), 32'd1);
        bus.eim_wr_n = 1'b1;
        cyc(6);
        bus_start(16'h0005);
        bus_read(got, oe_seen, wpulse, exp);
        chk("abort_mem_kept", 32'(got), 32'h5555);
        bus_end();

        // Reset in the middle of a read burst with OE held low
        bus_start(16'h0000);
        bus_write(16'h6666);
        bus.eim_oe_n = 1'b0;
        cyc(6);
        chk("rst_pre_da_oe", 32'(bus.eim_da_oe),  32'd1);
        chk("rst_pre_data",  32'(bus.eim_da_out), 32'h0022);
        chk("rst_pre_reg0",  32'(reg0),           32'h6666);
        rst = 1'b1;
        #1;
        chk("rst_da_oe",  32'(bus.eim_da_oe),  32'd0);
        chk("rst_wait_n", 32'(bus.eim_wait_n), 32'd1);
        chk("rst_reg0",   32'(reg0),           32'd0);
        chk("rst_err",    32'(err_oor),        32'd0);
        bus.eim_oe_n  = 1'b1;
        bus.eim_cs0_n = 1'b1;
        cyc(2);
        rst = 1'b0;
        m_reset();
        cyc(4);
        bus_start(16'h0000);
        for (int w = 0; w < DEPTH; w++) begin
            bus_read(got, oe_seen, wpulse, exp);
            chk($sformatf("rst_clear_w%0d", w), 32'(got), 32'd0);
        end
        bus_end();
        chk("rst_sweep_err", 32'(err_oor), 32'(m_err));

        // Randomized bursts against the model
        for (int t = 0; t < 40; t++) begin
            int            r, a, nb;
            logic [DW-1:0] d;
            r = $urandom_range(0, 9);
            if (r == 0)      a = 8'hFF;
            else if (r == 1) a = $urandom_range(16, 30);
            else             a = $urandom_range(0, DEPTH - 1);
            bus_start({8'($urandom_range(0, 255)), 8'(a)});
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 1) == 1) begin
                    d = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                    bus_write(d);
                end else begin
                    bus_read(got, oe_seen, wpulse, exp);
                    chk($sformatf("rnd%0d_b%0d_data", t, b), 32'(got), 32'(exp));
                    chk($sformatf("rnd%0d_b%0d_oe", t, b),   32'(oe_seen), 32'd1);
                end
                chk($sformatf("rnd%0d_b%0d_err", t, b),  32'(err_oor), 32'(m_err));
                chk($sformatf("rnd%0d_b%0d_reg0", t, b), 32'(reg0),    32'(m_mem[0]));
            end
            bus_end();
            chk($sformatf("rnd%0d_idle_wait", t), 32'(bus.eim_wait_n), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
